softex_tcdm_arbiter: RTL and testbench
======================================

# softex_tcdm_arbiter

Round-robin arbiter that shares the single wide HCI-style TCDM master port of the SoftEx accelerator between N_REQ internal streamers (e.g. source loads, sink stores, accumulator spill). It owns request selection, grant locking while the memory side stalls, and in-order routing of read responses back to the issuing streamer via an outstanding-read ordering FIFO. It sits between the streamers and the wrapper-level TCDM port.

## Interface
- N_REQ, 2, number of requesters (2..8)
- DW, 128, data width; BE width DW/8
- AW, 32, address width
- MAX_OUTST, 4, max outstanding reads; power of 2, ≥2
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_req_i  in  N_REQ  per-requester request
- req_gnt_o  out  N_REQ  per-requester grant (one-hot or zero)
- req_add_i  in  N_REQ×AW  address
- req_wen_i  in  N_REQ  1 = read, 0 = write (HCI convention)
- req_be_i  in  N_REQ×DW/8  byte enables
- req_data_i  in  N_REQ×DW  write data
- req_r_data_o  out  DW  response data, broadcast to all requesters
- req_r_valid_o  out  N_REQ  response valid, one-hot or zero
- req_r_ready_i  in  N_REQ  response ready
- tcdm_req_o / tcdm_gnt_i  out/in  1  master request / grant
- tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o  out  AW, 1, DW/8, DW  forwarded request fields
- tcdm_r_data_i / tcdm_r_valid_i  in  DW / 1  master response
- tcdm_r_ready_o  out  1  master response ready
- stall_cnt_o  out  32  cycles with tcdm_req_o & ~tcdm_gnt_i
- rsp_err_o  out  1  sticky: response received with no outstanding read

## Operation
- State: RR pointer ptr (clog2 N_REQ bits), lock flag + locked index, ordering FIFO of requester indices (depth MAX_OUTST), outstanding count cnt (0..MAX_OUTST).
- Selection: if lock set, sel = locked index; else sel = first i with req_req_i[i], scanning ptr, ptr+1, … modulo N_REQ.
- Read blocking: candidate with wen=1 is skipped (not eligible) when cnt == MAX_OUTST; writes remain eligible. Push blocked at full even if a pop occurs same cycle.
- tcdm_req_o = eligible sel exists; tcdm_add/wen/be/data_o = fields of sel (zero when no request).
- req_gnt_o[sel] = tcdm_gnt_i & tcdm_req_o; all other bits 0.
- Lock: tcdm_req_o & ~tcdm_gnt_i → lock set to sel next cycle; cleared on handshake. Requesters must hold req stable until granted (HCI rule); locked index keeps priority even if a higher-RR requester appears.
- Handshake (req & gnt): ptr ← sel+1 mod N_REQ; if wen=1, push sel to FIFO, cnt+1.
- Writes produce no response and no FIFO entry.
- Response routing: head = FIFO head. cnt>0: req_r_valid_o[head] = tcdm_r_valid_i, tcdm_r_ready_o = req_r_ready_i[head]; pop and cnt−1 on tcdm_r_valid_i & tcdm_r_ready_o. cnt==0: req_r_valid_o = 0, tcdm_r_ready_o = 1 (drain), and a valid response sets rsp_err_o.
- Simultaneous push and pop: cnt unchanged, both pointers advance.

## Timing
- Request path combinational: 0-cycle latency req_req_i → tcdm_req_o, tcdm_gnt_i → req_gnt_o.
- Response path combinational: 0-cycle tcdm_r_valid_i → req_r_valid_o.
- Issued read visible at FIFO head no earlier than the cycle after its grant.
- One request per cycle max; back-to-back grants to different requesters allowed every cycle.
- Reset (rst_i high at clk_i edge): ptr=0, lock cleared, FIFO empty, cnt=0, stall_cnt_o=0, rsp_err_o=0. While rst_i high: tcdm_req_o=0, req_gnt_o=0, req_r_valid_o=0, tcdm_r_ready_o=1, tcdm_add/wen/be/data_o=0.
- Reset mid-operation: in-flight reads forgotten; their later responses drained and flag rsp_err_o.

## Configuration
- SOFTEX_TCDM_ARB_STATS_EN defined: stall_cnt_o counts stall cycles (saturates at 2^32−1), rsp_err_o sticky as above, both cleared only by reset.
- Not defined: counter and flag logic removed; stall_cnt_o and rsp_err_o tied to 0. Arbitration and routing unchanged.

## Test plan
- N_REQ=2, both request reads every cycle, gnt=1 always → grants alternate 0,1,0,1; responses with 1-cycle delay route r_valid to 0,1,0,1 in order.
- Req0 read asserted, gnt=0 for 3 cycles, req1 raised in cycle 2 → req0 held selected, granted cycle 4, req1 granted cycle 5; stall_cnt_o=3 (macro on).
- MAX_OUTST=4, req0 issues 4 reads with no responses, then req0 read + req1 write → read blocked, req1 write granted; after one response, req0 read granted.
- Response with req_r_ready_i[head]=0 for 2 cycles → tcdm_r_ready_o=0, FIFO not popped, data delivered on cycle 3 to correct requester.
- Response with cnt=0 → tcdm_r_ready_o=1, all req_r_valid_o=0, rsp_err_o=1 (0 with macro off).
- Reset asserted with 2 reads outstanding → cnt=0, ptr=0; first post-reset request from req1 granted immediately with req0 idle.

Source files
------------

// File: rtl/softex_tcdm_arbiter_if.sv
// rtl/softex_tcdm_arbiter_if.sv - requester-side and TCDM-side bus bundle for softex_tcdm_arbiter
interface softex_tcdm_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 128,
    parameter int AW    = 32
);
    logic [N_REQ-1:0]             req_req;
    logic [N_REQ-1:0]             req_gnt;
    logic [N_REQ-1:0][AW-1:0]     req_add;
    logic [N_REQ-1:0]             req_wen;
    logic [N_REQ-1:0][DW/8-1:0]   req_be;
    logic [N_REQ-1:0][DW-1:0]     req_data;
    logic [DW-1:0]                req_r_data;
    logic [N_REQ-1:0]             req_r_valid;
    logic [N_REQ-1:0]             req_r_ready;

    logic                         tcdm_req;
    logic                         tcdm_gnt;
    logic [AW-1:0]                tcdm_add;
    logic                         tcdm_wen;
    logic [DW/8-1:0]              tcdm_be;
    logic [DW-1:0]                tcdm_data;
    logic [DW-1:0]                tcdm_r_data;
    logic                         tcdm_r_valid;
    logic                         tcdm_r_ready;

    modport slave (
        input  req_req, req_add, req_wen, req_be, req_data, req_r_ready,
        output req_gnt, req_r_data, req_r_valid,
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, tcdm_r_ready,
        input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );

    modport master (
        output req_req, req_add, req_wen, req_be, req_data, req_r_ready,
        input  req_gnt, req_r_data, req_r_valid,
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data, tcdm_r_ready,
        output tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );
endinterface

// File: rtl/softex_tcdm_arbiter.sv
// rtl/softex_tcdm_arbiter.sv - round-robin TCDM arbiter with in-order read routing; SOFTEX_TCDM_ARB_STATS_EN enables stall counter and response error flag
module softex_tcdm_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DW        = 128,
    parameter int AW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    softex_tcdm_arbiter_if.slave  bus,
    output logic [31:0]           stall_cnt_o,
    output logic                  rsp_err_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [IW-1:0] ptr_q;
    logic          lock_q;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] fifo_q [MAX_OUTST];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;

    logic          full, empty, found, active, hs, push, pop;
    logic [IW-1:0] sel, cand_idx, head;

    assign full  = (cnt_q == CW'(MAX_OUTST));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // A read candidate is skipped while the ordering FIFO is full; writes never block.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        cand_idx = '0;
        if (lock_q) begin
            sel   = lock_idx_q;
            found = bus.req_req[lock_idx_q] && !(bus.req_wen[lock_idx_q] && full);
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand_idx = IW'((int'(ptr_q) + k) % N_REQ);
                if (!found && bus.req_req[cand_idx] && !(bus.req_wen[cand_idx] && full)) begin
                    found = 1'b1;
                    sel   = cand_idx;
                end
            end
        end
    end

    assign active = found & ~rst_i;
    assign hs     = active & bus.tcdm_gnt;
    assign push   = hs & bus.req_wen[sel];
    assign pop    = ~rst_i & ~empty & bus.tcdm_r_valid & bus.req_r_ready[head];

    always_comb begin
        bus.tcdm_req  = active;
        bus.tcdm_add  = '0;
        bus.tcdm_wen  = 1'b0;
        bus.tcdm_be   = '0;
        bus.tcdm_data = '0;
        bus.req_gnt   = '0;
        if (active) begin
            bus.tcdm_add  = bus.req_add[sel];
            bus.tcdm_wen  = bus.req_wen[sel];
            bus.tcdm_be   = bus.req_be[sel];
            bus.tcdm_data = bus.req_data[sel];
        end
        if (hs) begin
            bus.req_gnt[sel] = 1'b1;
        end
    end

    // With nothing outstanding the response port drains unconditionally.
    always_comb begin
        bus.req_r_data   = bus.tcdm_r_data;
        bus.req_r_valid  = '0;
        bus.tcdm_r_ready = 1'b1;
        if (!rst_i && !empty) begin
            bus.req_r_valid[head] = bus.tcdm_r_valid;
            bus.tcdm_r_ready      = bus.req_r_ready[head];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (hs) begin
                ptr_q <= (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
            end
            lock_q     <= active & ~bus.tcdm_gnt;
            lock_idx_q <= sel;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

`ifdef SOFTEX_TCDM_ARB_STATS_EN
    logic [31:0] stall_q;
    logic        err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (active && !bus.tcdm_gnt && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (empty && bus.tcdm_r_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
    assign rsp_err_o   = err_q;
`else
    assign stall_cnt_o = '0;
    assign rsp_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_softex_tcdm_arbiter.sv
// tb/tb_softex_tcdm_arbiter.sv - self-checking bench for softex_tcdm_arbiter
module tb_softex_tcdm_arbiter;
    localparam int N  = 3;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int MO = 4;
`ifdef SOFTEX_TCDM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_cnt;
    logic        rsp_err;

    always #5 clk = ~clk;

    softex_tcdm_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) bus ();

    softex_tcdm_arbiter #(.N_REQ(N), .DW(DW), .AW(AW), .MAX_OUTST(MO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .stall_cnt_o (stall_cnt),
        .rsp_err_o   (rsp_err)
    );

    int checks   = 0;
    int failures = 0;

    int     m_ptr;
    bit     m_lock;
    int     m_lidx;
    int     m_q[$];
    longint m_stall;
    bit     m_err;

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void model_sel(output bit f, output int s);
        f = 1'b0;
        s = 0;
        if (m_lock) begin
            s = m_lidx;
            f = bus.req_req[s] && !(bus.req_wen[s] && m_q.size() == MO);
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!f && bus.req_req[c] && !(bus.req_wen[c] && m_q.size() == MO)) begin
                    f = 1'b1;
                    s = c;
                end
            end
        end
    endfunction

    task automatic model_step();
        bit f;
        int s;
        bit pop;
        model_sel(f, s);
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_lidx = 0; m_q.delete(); m_stall = 0; m_err = 0;
            return;
        end
        pop = (m_q.size() > 0) && bus.tcdm_r_valid && bus.req_r_ready[m_q[0]];
        if (m_q.size() == 0 && bus.tcdm_r_valid) m_err = 1'b1;
        if (f && !bus.tcdm_gnt && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_lock = f && !bus.tcdm_gnt;
        m_lidx = s;
        if (pop) void'(m_q.pop_front());
        if (f && bus.tcdm_gnt) begin
            m_ptr = (s + 1) % N;
            if (bus.req_wen[s]) m_q.push_back(s);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_req      = '0;
        bus.req_wen      = '0;
        bus.req_add      = '0;
        bus.req_be       = '0;
        bus.req_data     = '0;
        bus.req_r_ready  = '1;
        bus.tcdm_gnt     = 1'b0;
        bus.tcdm_r_valid = 1'b0;
        bus.tcdm_r_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req_req = '1; bus.req_wen = '1; bus.tcdm_gnt = 1'b1; bus.tcdm_r_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_add[i] = $urandom; bus.req_data[i] = rnd_data(); bus.req_be[i] = '1;
        end
        @(negedge clk);
        checks++; if (bus.tcdm_req !== 1'b0) begin failures++; $display("FAIL rst_tcdm_req got=%b exp=0", bus.tcdm_req); end
        checks++; if (bus.req_gnt !== '0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", bus.req_gnt); end
        checks++; if (bus.req_r_valid !== '0) begin failures++; $display("FAIL rst_r_valid got=%b exp=0", bus.req_r_valid); end
        checks++; if (bus.tcdm_r_ready !== 1'b1) begin failures++; $display("FAIL rst_r_ready got=%b exp=1", bus.tcdm_r_ready); end
        checks++; if (bus.tcdm_add !== '0 || bus.tcdm_data !== '0 || bus.tcdm_be !== '0 || bus.tcdm_wen !== 1'b0) begin
            failures++; $display("FAIL rst_fields add=%h wen=%b be=%h exp=0", bus.tcdm_add, bus.tcdm_wen, bus.tcdm_be);
        end
        tick();
        tick();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d;
        do_reset();
        bus.req_req = 3'b011; bus.req_wen = 3'b011; bus.tcdm_gnt = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) bus.req_req = '0;
            bus.tcdm_r_valid = (c >= 1);
            d = rnd_data();
            bus.tcdm_r_data = d;
            @(negedge clk);
            if (c < 6) begin
                checks++;
                if (bus.req_gnt !== 3'(1 << (c % 2))) begin
                    failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.req_gnt, 3'(1 << (c % 2)));
                end
            end
            if (c >= 1) begin
                checks++;
                if (bus.req_r_valid !== 3'(1 << ((c - 1) % 2)) || bus.req_r_data !== d) begin
                    failures++; $display("FAIL rr_rsp c=%0d got=%b exp=%b", c, bus.req_r_valid, 3'(1 << ((c - 1) % 2)));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        bus.req_req = 3'b001; bus.req_wen = 3'b000; bus.tcdm_gnt = 1'b1;
        bus.req_add[0] = 32'h0000_1000; bus.req_add[1] = 32'h0000_2000;
        @(negedge clk);
        checks++; if (bus.req_gnt !== 3'b001) begin failures++; $display("FAIL lock_pre got=%b exp=001", bus.req_gnt); end
        tick();
        bus.req_wen = 3'b011; bus.tcdm_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.req_req = 3'b011;
            if (c == 3) bus.tcdm_gnt = 1'b1;
            if (c == 4) bus.req_req = 3'b010;
            @(negedge clk);
            checks++;
            if (c < 3) begin
                if (bus.req_gnt !== 3'b000 || bus.tcdm_req !== 1'b1 || bus.tcdm_add !== 32'h0000_1000) begin
                    failures++; $display("FAIL lock_hold c=%0d gnt=%b req=%b add=%h exp=000/1/1000", c, bus.req_gnt, bus.tcdm_req, bus.tcdm_add);
                end
            end else if (c == 3) begin
                if (bus.req_gnt !== 3'b001) begin failures++; $display("FAIL lock_gnt0 got=%b exp=001", bus.req_gnt); end
            end else begin
                if (bus.req_gnt !== 3'b010 || bus.tcdm_add !== 32'h0000_2000) begin
                    failures++; $display("FAIL lock_gnt1 got=%b add=%h exp=010/2000", bus.req_gnt, bus.tcdm_add);
                end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== (STATS ? 32'd3 : 32'd0)) begin
            failures++; $display("FAIL lock_stall got=%0d exp=%0d", stall_cnt, STATS ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_read_block();
        do_reset();
        bus.req_req = 3'b001; bus.req_wen = 3'b001; bus.tcdm_gnt = 1'b1;
        for (int c = 0; c < MO; c++) begin
            @(negedge clk);
            checks++; if (bus.req_gnt !== 3'b001) begin failures++; $display("FAIL blk_fill c=%0d got=%b exp=001", c, bus.req_gnt); end
            tick();
        end
        bus.req_req = 3'b011; bus.req_wen = 3'b001;
        @(negedge clk);
        checks++; if (bus.req_gnt !== 3'b010 || bus.tcdm_wen !== 1'b0) begin
            failures++; $display("FAIL blk_write got=%b wen=%b exp=010/0", bus.req_gnt, bus.tcdm_wen);
        end
        tick();
        bus.req_req = 3'b001;
        @(negedge clk);
        checks++; if (bus.tcdm_req !== 1'b0 || bus.req_gnt !== 3'b000) begin
            failures++; $display("FAIL blk_full got=%b/%b exp=0/000", bus.tcdm_req, bus.req_gnt);
        end
        tick();
        bus.tcdm_r_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.tcdm_req !== 1'b0 || bus.req_r_valid !== 3'b001) begin
            failures++; $display("FAIL blk_pop_same got=%b/%b exp=0/001", bus.tcdm_req, bus.req_r_valid);
        end
        tick();
        bus.tcdm_r_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_gnt !== 3'b001) begin failures++; $display("FAIL blk_resume got=%b exp=001", bus.req_gnt); end
        tick();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        do_reset();
        bus.req_req = 3'b010; bus.req_wen = 3'b010; bus.tcdm_gnt = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_gnt !== 3'b010) begin failures++; $display("FAIL bp_gnt got=%b exp=010", bus.req_gnt); end
        tick();
        d = rnd_data();
        idle_inputs();
        bus.tcdm_r_valid = 1'b1; bus.tcdm_r_data = d; bus.req_r_ready = 3'b101;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.req_r_ready = 3'b111;
            @(negedge clk);
            checks++;
            if (bus.tcdm_r_ready !== (c == 2) || bus.req_r_valid !== 3'b010 || bus.req_r_data !== d) begin
                failures++; $display("FAIL bp_rsp c=%0d rdy=%b vld=%b exp=%b/010", c, bus.tcdm_r_ready, bus.req_r_valid, c == 2);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if (rsp_err !== 1'b0 || bus.req_r_valid !== '0) begin
            failures++; $display("FAIL bp_after err=%b vld=%b exp=0/000", rsp_err, bus.req_r_valid);
        end
        tick();
    endtask

    task automatic test_rsp_err();
        do_reset();
        bus.tcdm_r_valid = 1'b1; bus.req_r_ready = '0;
        @(negedge clk);
        checks++; if (bus.tcdm_r_ready !== 1'b1 || bus.req_r_valid !== '0) begin
            failures++; $display("FAIL err_drain rdy=%b vld=%b exp=1/000", bus.tcdm_r_ready, bus.req_r_valid);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (rsp_err !== STATS) begin failures++; $display("FAIL err_flag got=%b exp=%b", rsp_err, STATS); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_req = 3'b011; bus.req_wen = 3'b011; bus.tcdm_gnt = 1'b1;
        tick();
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tcdm_r_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_r_valid !== '0 || bus.tcdm_r_ready !== 1'b1) begin
            failures++; $display("FAIL mid_drain vld=%b rdy=%b exp=000/1", bus.req_r_valid, bus.tcdm_r_ready);
        end
        tick();
        idle_inputs();
        bus.req_req = 3'b010; bus.req_wen = 3'b010; bus.tcdm_gnt = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_gnt !== 3'b010) begin failures++; $display("FAIL mid_gnt got=%b exp=010", bus.req_gnt); end
        checks++; if (rsp_err !== STATS) begin failures++; $display("FAIL mid_err got=%b exp=%b", rsp_err, STATS); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        bit f;
        int s;
        logic [N-1:0] e_gnt, e_rv;
        logic e_rr;
        logic [31:0] e_stall;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_req[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_req[i]  = 1'b1;
                    bus.req_wen[i]  = $urandom_range(0, 3) != 0;
                    bus.req_add[i]  = $urandom;
                    bus.req_be[i]   = DW'(rnd_data());
                    bus.req_data[i] = rnd_data();
                end
            end
            bus.tcdm_gnt     = $urandom_range(0, 3) != 0;
            bus.tcdm_r_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            bus.req_r_ready  = N'($urandom);
            bus.tcdm_r_data  = rnd_data();
            @(negedge clk);
            model_sel(f, s);
            e_gnt = '0;
            if (f && bus.tcdm_gnt) e_gnt[s] = 1'b1;
            e_rv = '0;
            e_rr = 1'b1;
            if (m_q.size() > 0) begin
                e_rv[m_q[0]] = bus.tcdm_r_valid;
                e_rr = bus.req_r_ready[m_q[0]];
            end
            e_stall = STATS ? 32'(m_stall) : 32'd0;
            checks++; if (bus.tcdm_req !== f) begin failures++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, bus.tcdm_req, f); end
            checks++; if (bus.req_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus.req_gnt, e_gnt); end
            checks++;
            if (bus.tcdm_add !== (f ? bus.req_add[s] : '0) || bus.tcdm_wen !== (f ? bus.req_wen[s] : 1'b0) ||
                bus.tcdm_be !== (f ? bus.req_be[s] : '0) || bus.tcdm_data !== (f ? bus.req_data[s] : '0)) begin
                failures++; $display("FAIL rnd_fields c=%0d add=%h wen=%b exp_sel=%0d found=%b", c, bus.tcdm_add, bus.tcdm_wen, s, f);
            end
            checks++; if (bus.req_r_valid !== e_rv) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, bus.req_r_valid, e_rv); end
            checks++; if (bus.tcdm_r_ready !== e_rr) begin failures++; $display("FAIL rnd_rready c=%0d got=%b exp=%b", c, bus.tcdm_r_ready, e_rr); end
            checks++; if (stall_cnt !== e_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, e_stall); end
            checks++; if (rsp_err !== (STATS & m_err)) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, rsp_err, STATS & m_err); end
            tick();
            if (f && e_gnt != '0) bus.req_req[s] = 1'b0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_ptr = 0; m_lock = 0; m_lidx = 0; m_stall = 0; m_err = 0;
        test_reset();
        test_round_robin();
        test_lock();
        test_read_block();
        test_backpressure();
        test_rsp_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
